frame_stream_reader: RTL and testbench

- Read-side sequencer for the grayscale frame store: walks an N×M 8-bit frame memory in raster order and presents the pixels as a ready/valid stream with x/y coordinates and frame/line markers.
- Sits between the pixel store, which is written by the grayscaling path, and downstream consumers such as the display or feature blocks.
- A small credit-managed FIFO absorbs the memory's one-cycle read latency, so downstream backpressure never loses pixels.

---
 rtl/frame_stream_reader_pkg.sv | 33 +++
 rtl/pixel_beat_fifo.sv | 52 +++++
 rtl/frame_stream_reader.sv | 152 +++++++++++++++
 tb/tb_frame_stream_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stream_reader_pkg.sv
// rtl/frame_stream_reader_pkg.sv - shared state encoding, dimensions and helpers for the frame reader
package frame_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int DEF_N = 480;
  localparam int DEF_M = 320;

  // Ceiling log2, never below 1 so derived vectors always have a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_X_W = clog2(DEF_M);
  localparam int DEF_Y_W = clog2(DEF_N);

  typedef struct packed {
    logic               eof;
    logic               eol;
    logic               sof;
    logic [DEF_Y_W-1:0] y;
    logic [DEF_X_W-1:0] x;
    logic [7:0]         data;
  } pix_beat_t;

endpackage

// File: rtl/pixel_beat_fifo.sv
// rtl/pixel_beat_fifo.sv - synchronous FIFO of tagged pixel beats with occupancy count
module pixel_beat_fifo
  import frame_stream_reader_pkg::*;
#(
  parameter int W     = 21,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_beat,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam int PW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_beat;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/frame_stream_reader.sv
// rtl/frame_stream_reader.sv - raster-order frame memory reader presenting a ready/valid pixel stream
module frame_stream_reader
  import frame_stream_reader_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int M      = DEF_M,
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rd_data,
  output logic [7:0]          pix_data,
  output logic [clog2(M)-1:0] pix_x,
  output logic [clog2(N)-1:0] pix_y,
  output logic                pix_sof,
  output logic                pix_eol,
  output logic                pix_eof,
  output logic                pix_valid,
  input  logic                pix_ready
);

  localparam int XW    = clog2(M);
  localparam int YW    = clog2(N);
  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * M - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(M - 1);

  typedef struct packed {
    logic          eof;
    logic          eol;
    logic          sof;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
    logic [7:0]    data;
  } beat_t;

  rd_state_t         state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic              inflight;
  logic              tag_eof, tag_eol, tag_sof;
  logic [XW-1:0]     tag_x;
  logic [YW-1:0]     tag_y;
  logic              issue, accept_start, pop;
  logic [CNT_W-1:0]  count;
  beat_t             push_beat, head;

  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    done         = 1'b0;
    accept_start = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept_start = 1'b1;
        state_nxt    = READ;
      end
      // Credits cover both queued beats and the read still in flight.
      READ: if ((count + CNT_W'(inflight)) < CNT_W'(DEPTH)) begin
        issue = 1'b1;
        if (addr == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: if (!inflight && count == '0) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt    = IDLE;
      issue        = 1'b0;
      done         = 1'b0;
      accept_start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      inflight <= 1'b0;
      tag_eof  <= 1'b0;
      tag_eol  <= 1'b0;
      tag_sof  <= 1'b0;
      tag_x    <= '0;
      tag_y    <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) begin
        tag_x   <= x_cnt;
        tag_y   <= y_cnt;
        tag_sof <= (addr == '0);
        tag_eol <= (x_cnt == X_LAST);
        tag_eof <= (addr == LAST_ADDR);
      end
      if (accept_start) begin
        addr  <= '0;
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (issue) begin
        addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  assign push_beat = {tag_eof, tag_eol, tag_sof, tag_y, tag_x, mem_rd_data};

  pixel_beat_fifo #(
    .W     ($bits(beat_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (inflight && !abort),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign busy      = (state != IDLE);
  assign mem_rd_en = issue;
  assign mem_addr  = addr;
  assign pix_valid = (count != '0);
  assign pop       = pix_valid && pix_ready;
  assign pix_data  = pix_valid ? head.data : 8'h00;
  assign pix_x     = pix_valid ? head.x    : '0;
  assign pix_y     = pix_valid ? head.y    : '0;
  assign pix_sof   = pix_valid && head.sof;
  assign pix_eol   = pix_valid && head.eol;
  assign pix_eof   = pix_valid && head.eof;

endmodule

// File: tb/tb_frame_stream_reader.sv
// tb/tb_frame_stream_reader.sv - self-checking bench for frame_stream_reader on a 4x3 frame
module tb_frame_stream_reader;

  localparam int N      = 4;
  localparam int M      = 3;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int NPIX   = N * M;

  logic              clk = 1'b0;
  logic              rst, start, abort, pix_ready;
  logic              busy, done, mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data, pix_data;
  logic [1:0]        pix_x, pix_y;
  logic              pix_sof, pix_eol, pix_eof, pix_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  frame_stream_reader #(
    .N(N), .M(M), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready)
  );

  // Frame memory: one-cycle read latency, contents addr + 0x10.
  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? ({4'h0, mem_addr} + 8'h10) : 8'h00;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] model_beat(input int k);
    logic [7:0] d;
    logic [1:0] xx, yy;
    d  = 8'(8'h10 + k);
    xx = 2'(k % M);
    yy = 2'(k / M);
    return {k == 0, (k % M) == M - 1, k == NPIX - 1, yy, xx, d};
  endfunction

  function automatic logic [14:0] dut_beat();
    return {pix_sof, pix_eol, pix_eof, pix_y, pix_x, pix_data};
  endfunction

  // Scoreboard state
  logic        mon_en = 1'b0;
  int          exp_k, issued, accepted, done_cnt;
  logic        prev_stall;
  logic [15:0] prev_vec;

  task automatic mon_reset();
    exp_k = 0; issued = 0; accepted = 0; done_cnt = 0;
    prev_stall = 1'b0; prev_vec = '0; mon_en = 1'b1;
  endtask

  task automatic monitor();
    @(negedge clk);
    if (mon_en) begin
      if (mem_rd_en) begin
        chk("credit_limit", int'((issued - accepted) < DEPTH), 1);
        chk("rd_addr", int'(mem_addr), issued);
        issued++;
      end
      if (prev_stall) chk("stall_hold", int'({pix_valid, dut_beat()}), int'(prev_vec));
      if (pix_valid && pix_ready) begin
        chk("beat", int'(dut_beat()), int'(model_beat(exp_k)));
        exp_k++;
        accepted++;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", accepted, NPIX);
      end
      prev_stall = pix_valid && !pix_ready;
      prev_vec   = {pix_valid, dut_beat()};
    end
  endtask

  task automatic tick();
    monitor();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 20 cycles
  task automatic run_frame(input int mode, input int extra_start_at, input string tag);
    int cyc;
    mon_reset();
    start = 1'b1;
    pix_ready = (mode == 0);
    tick();
    start = 1'b0;
    cyc = 1;
    while (done_cnt == 0 && cyc < 400) begin
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = (cyc >= 20);
      endcase
      start = (cyc == extra_start_at);
      if (mode == 2 && cyc == 20) chk({tag, "_reads_while_stalled"}, issued, DEPTH);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_beats"}, accepted, NPIX);
    pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle_after"}, int'(busy), 0);
  endtask

  typedef struct {
    logic       start;
    logic       busy, rd_en, valid, done;
    logic [3:0] addr;
    logic [14:0] beat;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < 17; c++) begin
      int k;
      k = c - 3;
      tbl[c].start = (c == 0);
      tbl[c].busy  = (c >= 1 && c <= 15);
      tbl[c].rd_en = (c >= 1 && c <= 12);
      tbl[c].addr  = 4'(c - 1);
      tbl[c].valid = (k >= 0 && k < NPIX);
      tbl[c].beat  = (k >= 0 && k < NPIX) ? model_beat(k) : '0;
      tbl[c].done  = (c == 15);
    end

    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({busy, done, mem_rd_en, mem_addr, pix_valid, dut_beat()}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", int'({busy, done, mem_rd_en, mem_addr, pix_valid, dut_beat()}), 0);

    // Back-to-back first frame, cycle-exact
    pix_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      start = tbl[c].start;
      @(negedge clk);
      chk($sformatf("t%0d_busy", c), int'(busy), int'(tbl[c].busy));
      chk($sformatf("t%0d_rd_en", c), int'(mem_rd_en), int'(tbl[c].rd_en));
      chk($sformatf("t%0d_valid", c), int'(pix_valid), int'(tbl[c].valid));
      chk($sformatf("t%0d_done", c), int'(done), int'(tbl[c].done));
      if (tbl[c].rd_en) chk($sformatf("t%0d_addr", c), int'(mem_addr), int'(tbl[c].addr));
      if (tbl[c].valid) chk($sformatf("t%0d_beat", c), int'(dut_beat()), int'(tbl[c].beat));
      @(posedge clk); #1;
    end
    start = 1'b0;

    for (int f = 0; f < 3; f++) run_frame(1, -1, $sformatf("random%0d", f));
    run_frame(2, -1, "stall20");
    run_frame(0, 5, "restart_ignored");

    // Abort in cycle 6, with a start in the same cycle
    mon_reset();
    start = 1'b1; pix_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_busy_drop", int'(busy), 0);
    chk("abort_valid_drop", int'(pix_valid), 0);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_stays_idle", int'(busy), 0);
    run_frame(0, -1, "post_abort");

    // Reset while draining
    mon_reset();
    start = 1'b1; pix_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 13; c++) tick();
    chk("drain_reached", int'({busy, mem_rd_en, pix_valid}), 3'b101);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_drain", int'({busy, done, mem_rd_en, mem_addr, pix_valid, dut_beat()}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle_after", int'({busy, done, pix_valid}), 0);
    run_frame(0, -1, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
